// File: rtl/mc_pkg.sv
// Shared types and constants for the mem_ctrl SRAM controller.
// Optional feature macro: MC_BYTE_EN (per-byte SRAM lane enables on writes).
package mc_pkg;

  localparam int MC_SRAM_AW = 18;
  localparam int MC_SRAM_DW = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_LO = 3'd1,
    ST_RD_HI = 3'd2,
    ST_WR_LO = 3'd3,
    ST_WR_HI = 3'd4
  } mc_state_t;

  typedef enum logic {
    SRC_IF  = 1'b0,
    SRC_MEM = 1'b1
  } mc_src_t;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic ub_n;
    logic lb_n;
  } mc_strobe_t;

  localparam mc_strobe_t MC_STROBES_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, ub_n: 1'b1, lb_n: 1'b1};

  // Each 32-bit word occupies two consecutive halfwords; h selects the upper one.
  function automatic logic [MC_SRAM_AW-1:0] mc_half_addr(input logic [15:0] word, input logic h);
    return {1'b0, word, h};
  endfunction

endpackage

// File: rtl/mc_sram_io.sv
// Registered SRAM pin drivers: every pin is loaded from its precomputed next value
// on the same edge so address, data and strobes always move together.
module mc_sram_io
  import mc_pkg::*;
#(
  parameter int AW = MC_SRAM_AW,
  parameter int DW = MC_SRAM_DW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] addr_next,
  input  logic [DW-1:0] dq_out_next,
  input  logic          dq_oe_next,
  input  logic          ce_n_next,
  input  logic          oe_n_next,
  input  logic          we_n_next,
  input  logic          ub_n_next,
  input  logic          lb_n_next,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_dq_out,
  output logic          sram_dq_oe,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n,
  output logic          sram_ub_n,
  output logic          sram_lb_n
);

  always_ff @(posedge clock) begin
    if (reset) begin
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= MC_STROBES_IDLE.ce_n;
      sram_oe_n   <= MC_STROBES_IDLE.oe_n;
      sram_we_n   <= MC_STROBES_IDLE.we_n;
      sram_ub_n   <= MC_STROBES_IDLE.ub_n;
      sram_lb_n   <= MC_STROBES_IDLE.lb_n;
    end else begin
      sram_addr   <= addr_next;
      sram_dq_out <= dq_out_next;
      sram_dq_oe  <= dq_oe_next;
      sram_ce_n   <= ce_n_next;
      sram_oe_n   <= oe_n_next;
      sram_we_n   <= we_n_next;
      sram_ub_n   <= ub_n_next;
      sram_lb_n   <= lb_n_next;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Two-port (fetch / data) controller moving 32-bit words as two 16-bit SRAM accesses.
// Optional feature macro: MC_BYTE_EN enables per-byte write lanes from mem_mc_be.
module mem_ctrl
  import mc_pkg::*;
#(
  parameter int SRAM_AW = MC_SRAM_AW,
  parameter int SRAM_DW = MC_SRAM_DW
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               if_mc_en,
  input  logic [17:0]        if_mc_addr,
  output logic [31:0]        mc_if_data,
  output logic               mc_if_valid,
  input  logic               mem_mc_en,
  input  logic               mem_mc_rw,
  input  logic [17:0]        mem_mc_addr,
  input  logic [31:0]        mem_mc_wdata,
  input  logic [3:0]         mem_mc_be,
  output logic [31:0]        mc_mem_rdata,
  output logic               mc_mem_valid,
  output logic               mc_stall,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  mc_state_t          state_reg, state_next;
  mc_src_t            src_reg, src_next;
  logic [15:0]        word_reg, word_next;
  logic [31:0]        wdata_reg, wdata_next;
  logic [15:0]        lo_reg;
  logic               write_accept;
  mc_strobe_t         strobe_next;
  logic [SRAM_AW-1:0] addr_next;
  logic [SRAM_DW-1:0] dq_out_next;
  logic               dq_oe_next;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{if_mc_addr[1:0], mem_mc_addr[1:0]};
  assign write_accept     = (state_reg == ST_IDLE) & mem_mc_en & mem_mc_rw;
  assign mc_stall         = (state_reg != ST_IDLE) | ((state_reg == ST_IDLE) & (if_mc_en | mem_mc_en));

`ifdef MC_BYTE_EN
  logic [3:0] be_reg, be_next;

  assign be_next = write_accept ? mem_mc_be : be_reg;

  always_ff @(posedge clock) begin
    if (reset) be_reg <= '0;
    else       be_reg <= be_next;
  end
`else
  logic unused_be;
  assign unused_be = ^mem_mc_be;
`endif

  // Arbitration: data port beats fetch; the next-state values also feed the pin registers.
  always_comb begin
    state_next = state_reg;
    src_next   = src_reg;
    word_next  = word_reg;
    wdata_next = wdata_reg;
    case (state_reg)
      ST_IDLE: begin
        if (mem_mc_en) begin
          src_next   = SRC_MEM;
          word_next  = mem_mc_addr[17:2];
          state_next = mem_mc_rw ? ST_WR_LO : ST_RD_LO;
          if (write_accept) wdata_next = mem_mc_wdata;
        end else if (if_mc_en) begin
          src_next   = SRC_IF;
          word_next  = if_mc_addr[17:2];
          state_next = ST_RD_LO;
        end
      end
      ST_RD_LO: state_next = ST_RD_HI;
      ST_RD_HI: state_next = ST_IDLE;
      ST_WR_LO: state_next = ST_WR_HI;
      ST_WR_HI: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_next   = mc_half_addr(word_next, (state_next == ST_RD_HI) || (state_next == ST_WR_HI));
    dq_out_next = (state_next == ST_WR_HI) ? wdata_next[31:16] : wdata_next[15:0];
    dq_oe_next  = (state_next == ST_WR_LO) || (state_next == ST_WR_HI);
    strobe_next = MC_STROBES_IDLE;
    case (state_next)
      ST_RD_LO, ST_RD_HI: strobe_next = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1, ub_n: 1'b0, lb_n: 1'b0};
      ST_WR_LO: begin
        strobe_next = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0, ub_n: 1'b0, lb_n: 1'b0};
`ifdef MC_BYTE_EN
        strobe_next.ub_n = ~be_next[1];
        strobe_next.lb_n = ~be_next[0];
`endif
      end
      ST_WR_HI: begin
        strobe_next = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0, ub_n: 1'b0, lb_n: 1'b0};
`ifdef MC_BYTE_EN
        strobe_next.ub_n = ~be_next[3];
        strobe_next.lb_n = ~be_next[2];
`endif
      end
      default: strobe_next = MC_STROBES_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      src_reg      <= SRC_IF;
      word_reg     <= '0;
      wdata_reg    <= '0;
      lo_reg       <= '0;
      mc_if_data   <= '0;
      mc_mem_rdata <= '0;
      mc_if_valid  <= 1'b0;
      mc_mem_valid <= 1'b0;
    end else begin
      state_reg    <= state_next;
      src_reg      <= src_next;
      word_reg     <= word_next;
      wdata_reg    <= wdata_next;
      mc_if_valid  <= 1'b0;
      mc_mem_valid <= 1'b0;
      if (state_reg == ST_RD_LO) lo_reg <= sram_dq_in;
      if (state_reg == ST_RD_HI) begin
        if (src_reg == SRC_IF) begin
          mc_if_data  <= {sram_dq_in, lo_reg};
          mc_if_valid <= 1'b1;
        end else begin
          mc_mem_rdata <= {sram_dq_in, lo_reg};
          mc_mem_valid <= 1'b1;
        end
      end
      if (state_reg == ST_WR_HI) mc_mem_valid <= 1'b1;
    end
  end

  mc_sram_io #(.AW(SRAM_AW), .DW(SRAM_DW)) u_io (
    .clock       (clock),
    .reset       (reset),
    .addr_next   (addr_next),
    .dq_out_next (dq_out_next),
    .dq_oe_next  (dq_oe_next),
    .ce_n_next   (strobe_next.ce_n),
    .oe_n_next   (strobe_next.oe_n),
    .we_n_next   (strobe_next.we_n),
    .ub_n_next   (strobe_next.ub_n),
    .lb_n_next   (strobe_next.lb_n),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_ce_n   (sram_ce_n),
    .sram_oe_n   (sram_oe_n),
    .sram_we_n   (sram_we_n),
    .sram_ub_n   (sram_ub_n),
    .sram_lb_n   (sram_lb_n)
  );

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural 16-bit asynchronous SRAM model.
// Honours MC_BYTE_EN for the partial-write expectation.
module tb_mem_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_mc_en = 1'b0;
  logic [17:0] if_mc_addr = '0;
  logic [31:0] mc_if_data;
  logic        mc_if_valid;
  logic        mem_mc_en = 1'b0;
  logic        mem_mc_rw = 1'b0;
  logic [17:0] mem_mc_addr = '0;
  logic [31:0] mem_mc_wdata = '0;
  logic [3:0]  mem_mc_be = '0;
  logic [31:0] mc_mem_rdata;
  logic        mc_mem_valid;
  logic        mc_stall;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  int total = 0;
  int bad   = 0;

  logic [15:0] sram_mem [0:511];
  logic        pre_we = 1'b0;
  logic [8:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;
  logic [4:0]  strobes;

  assign strobes    = {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n};
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[8:0]] : 16'hxxxx;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (pre_we) begin
      sram_mem[pre_addr] <= pre_data;
    end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      if (!sram_lb_n) sram_mem[sram_addr[8:0]][7:0]  <= sram_dq_out[7:0];
      if (!sram_ub_n) sram_mem[sram_addr[8:0]][15:8] <= sram_dq_out[15:8];
    end
  end

  mem_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .if_mc_en     (if_mc_en),
    .if_mc_addr   (if_mc_addr),
    .mc_if_data   (mc_if_data),
    .mc_if_valid  (mc_if_valid),
    .mem_mc_en    (mem_mc_en),
    .mem_mc_rw    (mem_mc_rw),
    .mem_mc_addr  (mem_mc_addr),
    .mem_mc_wdata (mem_mc_wdata),
    .mem_mc_be    (mem_mc_be),
    .mc_mem_rdata (mc_mem_rdata),
    .mc_mem_valid (mc_mem_valid),
    .mc_stall     (mc_stall),
    .sram_addr    (sram_addr),
    .sram_dq_out  (sram_dq_out),
    .sram_dq_in   (sram_dq_in),
    .sram_dq_oe   (sram_dq_oe),
    .sram_ce_n    (sram_ce_n),
    .sram_oe_n    (sram_oe_n),
    .sram_we_n    (sram_we_n),
    .sram_ub_n    (sram_ub_n),
    .sram_lb_n    (sram_lb_n)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic poke(input logic [8:0] a, input logic [15:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  // Single data-port read started in the current IDLE cycle; result checked at N+3.
  task automatic mem_read(input string tag, input logic [17:0] a, input logic [31:0] want);
    mem_mc_en = 1'b1; mem_mc_rw = 1'b0; mem_mc_addr = a;
    tick();
    mem_mc_en = 1'b0;
    tick();
    tick();
    check({tag, "_valid"}, {31'd0, mc_mem_valid}, 32'd1);
    check({tag, "_data"}, mc_mem_rdata, want);
    $display("txn read  addr=%h data=%h", a, mc_mem_rdata);
    tick();
  endtask

  task automatic mem_write(input logic [17:0] a, input logic [31:0] d, input logic [3:0] be);
    mem_mc_en = 1'b1; mem_mc_rw = 1'b1; mem_mc_addr = a; mem_mc_wdata = d; mem_mc_be = be;
    tick();
    mem_mc_en = 1'b0;
    tick();
    tick();
    check("wr_valid", {31'd0, mc_mem_valid}, 32'd1);
    $display("txn write addr=%h data=%h be=%b", a, d, be);
    tick();
  endtask

  initial begin
    logic [31:0] be_expect;

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    check("rst_if_data", mc_if_data, 32'h0);
    check("rst_mem_rdata", mc_mem_rdata, 32'h0);
    check("rst_valids", {30'd0, mc_if_valid, mc_mem_valid}, 32'd0);
    check("rst_stall", {31'd0, mc_stall}, 32'd0);
    check("rst_strobes", {27'd0, strobes}, 32'h1f);
    check("rst_addr", {14'd0, sram_addr}, 32'd0);
    check("rst_dq", {15'd0, sram_dq_oe, sram_dq_out}, 32'd0);

    // Fetch only: byte 0x40 -> halfwords 0x20 / 0x21
    poke(9'h020, 16'hBEEF);
    poke(9'h021, 16'hDEAD);
    poke(9'h000, 16'h1111);
    poke(9'h001, 16'h2222);
    poke(9'h004, 16'h3333);
    poke(9'h005, 16'h4444);
    if_mc_addr = 18'h00040; if_mc_en = 1'b1;
    #1;
    check("f_stall_n", {31'd0, mc_stall}, 32'd1);
    tick();
    if_mc_en = 1'b0;
    check("f_lo_addr", {14'd0, sram_addr}, 32'h20);
    check("f_lo_strobes", {27'd0, strobes}, 32'h04);
    check("f_lo_oe", {31'd0, sram_dq_oe}, 32'd0);
    tick();
    check("f_hi_addr", {14'd0, sram_addr}, 32'h21);
    check("f_hi_valid", {31'd0, mc_if_valid}, 32'd0);
    tick();
    check("f_valid", {31'd0, mc_if_valid}, 32'd1);
    check("f_data", mc_if_data, 32'hDEADBEEF);
    check("f_stall_drop", {31'd0, mc_stall}, 32'd0);
    check("f_idle_strobes", {27'd0, strobes}, 32'h1f);
    $display("txn fetch addr=%h data=%h", if_mc_addr, mc_if_data);
    tick();
    check("f_pulse", {31'd0, mc_if_valid}, 32'd0);

    // Simultaneous fetch at 0x0 and data read at 0x8
    if_mc_addr = 18'h0; if_mc_en = 1'b1;
    mem_mc_addr = 18'h8; mem_mc_rw = 1'b0; mem_mc_en = 1'b1;
    tick();
    mem_mc_en = 1'b0;
    check("s_data_first", {14'd0, sram_addr}, 32'h4);
    tick();
    check("s_stall2", {31'd0, mc_stall}, 32'd1);
    tick();
    check("s_mem_valid3", {31'd0, mc_mem_valid}, 32'd1);
    check("s_mem_data3", mc_mem_rdata, 32'h44443333);
    check("s_if_valid3", {31'd0, mc_if_valid}, 32'd0);
    check("s_stall3", {31'd0, mc_stall}, 32'd1);
    $display("txn read  addr=%h data=%h", mem_mc_addr, mc_mem_rdata);
    tick();
    if_mc_en = 1'b0;
    check("s_fetch_addr4", {14'd0, sram_addr}, 32'h0);
    check("s_stall4", {31'd0, mc_stall}, 32'd1);
    tick();
    check("s_stall5", {31'd0, mc_stall}, 32'd1);
    tick();
    check("s_if_valid6", {31'd0, mc_if_valid}, 32'd1);
    check("s_if_data6", mc_if_data, 32'h22221111);
    check("s_stall6", {31'd0, mc_stall}, 32'd0);
    $display("txn fetch addr=%h data=%h", if_mc_addr, mc_if_data);
    tick();

    // Write then read back at 0x100 -> halfwords 0x80 / 0x81
    mem_mc_en = 1'b1; mem_mc_rw = 1'b1; mem_mc_addr = 18'h100;
    mem_mc_wdata = 32'h12345678; mem_mc_be = 4'hF;
    tick();
    mem_mc_en = 1'b0;
    check("w_lo_pins", {sram_dq_oe, 13'd0, sram_addr}, 32'h8000_0080);
    check("w_lo_dq", {16'd0, sram_dq_out}, 32'h5678);
    check("w_lo_strobes", {27'd0, strobes}, 32'h08);
    tick();
    check("w_hi_addr", {14'd0, sram_addr}, 32'h81);
    check("w_hi_dq", {16'd0, sram_dq_out}, 32'h1234);
    tick();
    check("w_valid", {31'd0, mc_mem_valid}, 32'd1);
    check("w_mem_lo", {16'd0, sram_mem[9'h080]}, 32'h5678);
    check("w_mem_hi", {16'd0, sram_mem[9'h081]}, 32'h1234);
    $display("txn write addr=%h data=%h be=%b", mem_mc_addr, mem_mc_wdata, mem_mc_be);
    tick();
    mem_read("wr_rd", 18'h100, 32'h12345678);

    // Partial write over all-ones word at 0x200 -> halfwords 0x100 / 0x101
    poke(9'h100, 16'hFFFF);
    poke(9'h101, 16'hFFFF);
    mem_write(18'h200, 32'h00AB0000, 4'b0100);
`ifdef MC_BYTE_EN
    be_expect = 32'hFFABFFFF;
`else
    be_expect = 32'h00AB0000;
`endif
    mem_read("be_rd", 18'h200, be_expect);

    // Reset during RD_HI aborts the fetch
    if_mc_addr = 18'h00040; if_mc_en = 1'b1;
    tick();
    if_mc_en = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("r_no_valid", {30'd0, mc_if_valid, mc_mem_valid}, 32'd0);
    check("r_if_data", mc_if_data, 32'h0);
    check("r_mem_rdata", mc_mem_rdata, 32'h0);
    check("r_strobes", {27'd0, strobes}, 32'h1f);
    reset = 1'b0;
    tick();
    check("r_no_late_valid", {30'd0, mc_if_valid, mc_mem_valid}, 32'd0);
    if_mc_en = 1'b1;
    tick();
    if_mc_en = 1'b0;
    tick();
    tick();
    check("r_recover_valid", {31'd0, mc_if_valid}, 32'd1);
    check("r_recover_data", mc_if_data, 32'hDEADBEEF);
    $display("txn fetch addr=%h data=%h", if_mc_addr, mc_if_data);
    tick();

    // Fetch address changed during RD_LO: latched address must be used
    if_mc_addr = 18'h0; if_mc_en = 1'b1;
    tick();
    if_mc_en = 1'b0;
    if_mc_addr = 18'h00040;
    tick();
    check("a_hi_addr", {14'd0, sram_addr}, 32'h1);
    tick();
    check("a_valid", {31'd0, mc_if_valid}, 32'd1);
    check("a_data", mc_if_data, 32'h22221111);
    $display("txn fetch addr=%h data=%h", 18'h0, mc_if_data);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
